// File: rtl/hires_pkg.sv
// Shared constants and types for the hires framebuffer access controller.
package hires_pkg;

    localparam int X_W        = 7;
    localparam int Y_W        = 8;
    localparam int HIRES_COLS = 80;
    localparam int HIRES_ROWS = 240;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/hires_fill_engine.sv
// Rectangle fill sequencer: walks x inside y over a latched window and
// requests one RAM write per cycle unless the Z80 holds the port.
module hires_fill_engine #(
    parameter int X_W = hires_pkg::X_W,
    parameter int Y_W = hires_pkg::Y_W
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           start,
    input  logic           abort,
    input  logic           stall,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    input  logic [7:0]     value,
    output logic           wr_req,
    output logic [X_W-1:0] wr_x,
    output logic [Y_W-1:0] wr_y,
    output logic [7:0]     wr_value,
    output logic           busy,
    output logic           done
);
    import hires_pkg::*;

    fill_state_t    state;
    logic [X_W-1:0] x0_q;
    logic [X_W-1:0] w_q;
    logic [Y_W-1:0] h_q;
    logic [7:0]     value_q;
    logic [X_W-1:0] cnt_x;
    logic [Y_W-1:0] cnt_y;
    logic [X_W-1:0] fx;
    logic [Y_W-1:0] fy;
    logic           last_col;
    logic           last_row;

    assign last_col = (cnt_x == w_q - X_W'(1));
    assign last_row = (cnt_y == h_q - Y_W'(1));
    assign wr_req   = (state == FILL_RUN) && !stall;
    assign wr_x     = fx;
    assign wr_y     = fy;
    assign wr_value = value_q;

    // Counters only advance on cycles whose write actually reached the port.
    always_ff @(posedge clk) begin
        if (srst) begin
            state   <= FILL_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            x0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            value_q <= '0;
            cnt_x   <= '0;
            cnt_y   <= '0;
            fx      <= '0;
            fy      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                FILL_IDLE: begin
                    if (start) begin
                        x0_q    <= x0;
                        w_q     <= w;
                        h_q     <= h;
                        value_q <= value;
                        fx      <= x0;
                        fy      <= y0;
                        cnt_x   <= '0;
                        cnt_y   <= '0;
                        busy    <= 1'b1;
                        if (w == '0 || h == '0) begin
                            state <= FILL_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FILL_RUN;
                        end
                    end
                end
                FILL_RUN: begin
                    if (abort || (wr_req && last_col && last_row)) begin
                        state <= FILL_DONE;
                        done  <= 1'b1;
                    end else if (wr_req) begin
                        if (last_col) begin
                            cnt_x <= '0;
                            fx    <= x0_q;
                            cnt_y <= cnt_y + Y_W'(1);
                            fy    <= fy + Y_W'(1);
                        end else begin
                            cnt_x <= cnt_x + X_W'(1);
                            fx    <= fx + X_W'(1);
                        end
                    end
                end
                FILL_DONE: begin
                    state <= FILL_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= FILL_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hires_access_ctrl.sv
// Hires framebuffer RAM port-A arbiter: Z80 data-port accesses always win,
// the fill engine uses the remaining cycles; reads return after three cycles.
module hires_access_ctrl #(
    parameter int X_W = hires_pkg::X_W,
    parameter int Y_W = hires_pkg::Y_W
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               z80_rd_req,
    input  logic               z80_wr_req,
    input  logic [X_W+Y_W-1:0] z80_addr,
    input  logic [7:0]         z80_wdata,
    output logic [7:0]         z80_rdata,
    output logic               z80_rd_rdy,
    input  logic               fill_start,
    input  logic               fill_abort,
    input  logic [X_W-1:0]     fill_x0,
    input  logic [Y_W-1:0]     fill_y0,
    input  logic [X_W-1:0]     fill_w,
    input  logic [Y_W-1:0]     fill_h,
    input  logic [7:0]         fill_value,
    output logic               fill_busy,
    output logic               fill_done,
    output logic               ram_ce,
    output logic               ram_we,
    output logic               ram_regce,
    output logic [X_W+Y_W-1:0] ram_addr,
    output logic [7:0]         ram_din,
    input  logic [7:0]         ram_dout
);

    logic           z80_any;
    logic           fill_wr;
    logic [X_W-1:0] fill_x;
    logic [Y_W-1:0] fill_y;
    logic [7:0]     fill_data;
    logic           rd_pend;

    assign z80_any = z80_rd_req || z80_wr_req;

    hires_fill_engine #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_fill (
        .clk      (clk),
        .srst     (srst),
        .start    (fill_start),
        .abort    (fill_abort),
        .stall    (z80_any),
        .x0       (fill_x0),
        .y0       (fill_y0),
        .w        (fill_w),
        .h        (fill_h),
        .value    (fill_value),
        .wr_req   (fill_wr),
        .wr_x     (fill_x),
        .wr_y     (fill_y),
        .wr_value (fill_data),
        .busy     (fill_busy),
        .done     (fill_done)
    );

    // ram_dout is captured in the regce cycle, so rd_rdy lands one cycle later.
    always_ff @(posedge clk) begin
        if (srst) begin
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_regce  <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            rd_pend    <= 1'b0;
            z80_rd_rdy <= 1'b0;
            z80_rdata  <= '0;
        end else begin
            rd_pend    <= z80_rd_req;
            ram_regce  <= rd_pend;
            z80_rd_rdy <= ram_regce;
            if (ram_regce) begin
                z80_rdata <= ram_dout;
            end
            if (z80_rd_req) begin
                ram_ce   <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= z80_addr;
            end else if (z80_wr_req) begin
                ram_ce   <= 1'b1;
                ram_we   <= 1'b1;
                ram_addr <= z80_addr;
                ram_din  <= z80_wdata;
            end else if (fill_wr) begin
                ram_ce   <= 1'b1;
                ram_we   <= 1'b1;
                ram_addr <= {fill_x, fill_y};
                ram_din  <= fill_data;
            end else begin
                ram_ce <= 1'b0;
                ram_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hires_access_ctrl.sv
// Directed bench for hires_access_ctrl with a behavioural port-A RAM and write log.
module tb_hires_access_ctrl;

    localparam int X_W = 7;
    localparam int Y_W = 8;
    localparam int A_W = X_W + Y_W;

    logic           clk = 1'b0;
    logic           srst;
    logic           z80_rd_req, z80_wr_req;
    logic [A_W-1:0] z80_addr;
    logic [7:0]     z80_wdata, z80_rdata;
    logic           z80_rd_rdy;
    logic           fill_start, fill_abort;
    logic [X_W-1:0] fill_x0, fill_w;
    logic [Y_W-1:0] fill_y0, fill_h;
    logic [7:0]     fill_value;
    logic           fill_busy, fill_done;
    logic           ram_ce, ram_we, ram_regce;
    logic [A_W-1:0] ram_addr;
    logic [7:0]     ram_din, ram_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hires_access_ctrl #(.X_W(X_W), .Y_W(Y_W)) dut (
        .clk        (clk),
        .srst       (srst),
        .z80_rd_req (z80_rd_req),
        .z80_wr_req (z80_wr_req),
        .z80_addr   (z80_addr),
        .z80_wdata  (z80_wdata),
        .z80_rdata  (z80_rdata),
        .z80_rd_rdy (z80_rd_rdy),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_regce  (ram_regce),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // Port-A RAM: one-cycle read latency, data held until the next read.
    logic [7:0] mem [0:(1<<A_W)-1];
    logic [7:0] ram_dout_q = 8'h00;
    assign ram_dout = ram_dout_q;

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout_q    <= mem[ram_addr];
        end
    end

    logic [A_W+7:0] wlog[$];
    always @(negedge clk) begin
        if (ram_ce && ram_we) wlog.push_back({ram_addr, ram_din});
    end

    function automatic logic [A_W+7:0] ent(input int x, input int y, input logic [7:0] v);
        logic [X_W-1:0] xs;
        logic [Y_W-1:0] ys;
        xs = X_W'(x);
        ys = Y_W'(y);
        return {xs, ys, v};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Leaves the bench in the first cycle after the start edge.
    task automatic start_fill(input int x0, input int y0, input int w, input int h,
                              input logic [7:0] v);
        fill_x0    = X_W'(x0);
        fill_y0    = Y_W'(y0);
        fill_w     = X_W'(w);
        fill_h     = Y_W'(h);
        fill_value = v;
        fill_start = 1'b1;
        wlog.delete();
        cyc();
        fill_start = 1'b0;
    endtask

    task automatic wait_done(input int first, input int last, output int at);
        at = -1;
        for (int c = first; c <= last; c++) begin
            cyc();
            if (fill_done === 1'b1 && at < 0) at = c;
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        cyc();
        cyc();
        srst = 1'b0;
        total++;
        if ({ram_ce, ram_we, ram_regce, z80_rd_rdy, fill_busy, fill_done} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {ram_ce, ram_we, ram_regce, z80_rd_rdy, fill_busy, fill_done});
        end
        total++;
        if (ram_addr !== '0) begin
            bad++;
            $display("[TB] FAIL reset_addr: got %h expected 0", ram_addr);
        end
        total++;
        if (ram_din !== 8'h00 || z80_rdata !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_data: got din=%h rdata=%h expected 00/00", ram_din, z80_rdata);
        end
    endtask

    task automatic test_fill_basic();
        logic [A_W+7:0] expq[$];
        int at;
        expq = '{ent(2,10,8'hA5), ent(3,10,8'hA5), ent(4,10,8'hA5),
                 ent(2,11,8'hA5), ent(3,11,8'hA5), ent(4,11,8'hA5)};
        start_fill(2, 10, 3, 2, 8'hA5);
        total++;
        if (fill_busy !== 1'b1 || ram_ce !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_first_cycle: got busy=%b ce=%b expected 1/0", fill_busy, ram_ce);
        end
        wait_done(2, 10, at);
        total++;
        if (at != 7) begin
            bad++;
            $display("[TB] FAIL basic_done_cycle: got %0d expected 7", at);
        end
        total++;
        if (wlog.size() != 6) begin
            bad++;
            $display("[TB] FAIL basic_write_count: got %0d expected 6", wlog.size());
        end
        for (int i = 0; i < expq.size(); i++) begin
            total++;
            if (i >= wlog.size() || wlog[i] !== expq[i]) begin
                bad++;
                $display("[TB] FAIL basic_write%0d: got %h expected %h", i, wlog[i], expq[i]);
            end
        end
        total++;
        if (fill_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_busy_end: got %b expected 0", fill_busy);
        end
    endtask

    task automatic test_wr_during_fill();
        logic [A_W+7:0] expq[$];
        int at;
        expq = '{ent(5,5,8'h3C),
                 ent(0,0,8'h11), ent(1,0,8'h11), ent(2,0,8'h11), ent(3,0,8'h11),
                 ent(0,1,8'h11), ent(1,1,8'h11), ent(2,1,8'h11), ent(3,1,8'h11)};
        start_fill(0, 0, 4, 2, 8'h11);
        z80_wr_req = 1'b1;
        z80_addr   = {7'd5, 8'd5};
        z80_wdata  = 8'h3C;
        cyc();
        z80_wr_req = 1'b0;
        total++;
        if ({ram_ce, ram_we} !== 2'b11 || ram_addr !== {7'd5, 8'd5} || ram_din !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL z80_wr_port: got ce=%b we=%b addr=%h din=%h expected 1 1 %h 3c",
                     ram_ce, ram_we, ram_addr, ram_din, {7'd5, 8'd5});
        end
        wait_done(3, 14, at);
        total++;
        if (at != 10) begin
            bad++;
            $display("[TB] FAIL stall_done_cycle: got %0d expected 10", at);
        end
        total++;
        if (wlog.size() != 9) begin
            bad++;
            $display("[TB] FAIL stall_write_count: got %0d expected 9", wlog.size());
        end
        for (int i = 0; i < expq.size(); i++) begin
            total++;
            if (i >= wlog.size() || wlog[i] !== expq[i]) begin
                bad++;
                $display("[TB] FAIL stall_write%0d: got %h expected %h", i, wlog[i], expq[i]);
            end
        end
    endtask

    task automatic test_simul_rdwr();
        z80_rd_req = 1'b1;
        z80_wr_req = 1'b1;
        z80_addr   = {7'd9, 8'd9};
        z80_wdata  = 8'h77;
        cyc();
        z80_rd_req = 1'b0;
        z80_wr_req = 1'b0;
        total++;
        if ({ram_ce, ram_we} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL simul_port: got ce/we=%b expected 10", {ram_ce, ram_we});
        end
        cyc();
        cyc();
        total++;
        if (z80_rd_rdy !== 1'b1 || z80_rdata !== 8'h00) begin
            bad++;
            $display("[TB] FAIL simul_read: got rdy=%b data=%h expected 1/00", z80_rd_rdy, z80_rdata);
        end
    endtask

    task automatic test_read_pipeline();
        z80_addr   = {7'd2, 8'd0};
        z80_rd_req = 1'b1;
        cyc();
        z80_addr = {7'd5, 8'd5};
        total++;
        if ({ram_ce, ram_we} !== 2'b10 || ram_addr !== {7'd2, 8'd0}) begin
            bad++;
            $display("[TB] FAIL read_issue: got ce/we=%b addr=%h expected 10 %h",
                     {ram_ce, ram_we}, ram_addr, {7'd2, 8'd0});
        end
        cyc();
        z80_rd_req = 1'b0;
        total++;
        if (ram_regce !== 1'b1 || z80_rd_rdy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL read_regce: got regce=%b rdy=%b expected 1/0", ram_regce, z80_rd_rdy);
        end
        cyc();
        total++;
        if (z80_rd_rdy !== 1'b1 || z80_rdata !== 8'h11) begin
            bad++;
            $display("[TB] FAIL read_first: got rdy=%b data=%h expected 1/11", z80_rd_rdy, z80_rdata);
        end
        cyc();
        total++;
        if (z80_rd_rdy !== 1'b1 || z80_rdata !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL read_second: got rdy=%b data=%h expected 1/3c", z80_rd_rdy, z80_rdata);
        end
        cyc();
        total++;
        if (z80_rd_rdy !== 1'b0 || z80_rdata !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL read_hold: got rdy=%b data=%h expected 0/3c", z80_rd_rdy, z80_rdata);
        end
    endtask

    task automatic test_wrap();
        logic [A_W+7:0] expq[$];
        int at;
        expq = '{ent(126,3,8'h5A), ent(127,3,8'h5A), ent(0,3,8'h5A), ent(1,3,8'h5A)};
        start_fill(126, 3, 4, 1, 8'h5A);
        wait_done(2, 8, at);
        total++;
        if (at != 5) begin
            bad++;
            $display("[TB] FAIL wrap_done_cycle: got %0d expected 5", at);
        end
        for (int i = 0; i < expq.size(); i++) begin
            total++;
            if (i >= wlog.size() || wlog[i] !== expq[i]) begin
                bad++;
                $display("[TB] FAIL wrap_write%0d: got %h expected %h", i, wlog[i], expq[i]);
            end
        end
        start_fill(1, 2, 0, 5, 8'hC3);
        total++;
        if (fill_done !== 1'b1 || fill_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL zero_w_done: got done=%b busy=%b expected 1/1", fill_done, fill_busy);
        end
        cyc();
        total++;
        if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_w_idle: got done=%b busy=%b expected 0/0", fill_done, fill_busy);
        end
        cyc();
        cyc();
        total++;
        if (wlog.size() != 0) begin
            bad++;
            $display("[TB] FAIL zero_w_writes: got %0d expected 0", wlog.size());
        end
    endtask

    task automatic test_abort();
        int at;
        start_fill(0, 0, 80, 240, 8'hEE);
        cyc();
        fill_w     = '0;
        fill_start = 1'b1;
        cyc();
        fill_start = 1'b0;
        cyc();
        cyc();
        fill_abort = 1'b1;
        cyc();
        fill_abort = 1'b0;
        total++;
        if (fill_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_done: got %b expected 1", fill_done);
        end
        cyc();
        total++;
        if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_idle: got busy=%b done=%b expected 0/0", fill_busy, fill_done);
        end
        total++;
        if (wlog.size() < 5 || wlog.size() > 6) begin
            bad++;
            $display("[TB] FAIL abort_write_count: got %0d expected 5..6", wlog.size());
        end
        start_fill(10, 20, 1, 1, 8'h99);
        total++;
        if (fill_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL restart_busy: got %b expected 1", fill_busy);
        end
        wait_done(2, 6, at);
        total++;
        if (at != 2 || wlog.size() != 1 || wlog[0] !== ent(10, 20, 8'h99)) begin
            bad++;
            $display("[TB] FAIL restart_fill: got done_at=%0d writes=%0d first=%h expected 2 1 %h",
                     at, wlog.size(), wlog[0], ent(10, 20, 8'h99));
        end
    endtask

    task automatic test_reset_mid();
        start_fill(0, 0, 80, 240, 8'hEE);
        cyc();
        cyc();
        z80_rd_req = 1'b1;
        z80_addr   = {7'd5, 8'd5};
        cyc();
        z80_rd_req = 1'b0;
        total++;
        if ({ram_ce, ram_we} !== 2'b10 || fill_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_pre: got ce/we=%b busy=%b expected 10/1", {ram_ce, ram_we}, fill_busy);
        end
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        total++;
        if ({ram_ce, ram_we, ram_regce, z80_rd_rdy, fill_busy, fill_done} !== 6'b0 ||
            ram_addr !== '0 || ram_din !== 8'h00 || z80_rdata !== 8'h00) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got flags=%b addr=%h din=%h rdata=%h expected all 0",
                     {ram_ce, ram_we, ram_regce, z80_rd_rdy, fill_busy, fill_done},
                     ram_addr, ram_din, z80_rdata);
        end
        cyc();
        total++;
        if (z80_rd_rdy !== 1'b0 || ram_regce !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_regce: got rdy=%b regce=%b expected 0/0", z80_rd_rdy, ram_regce);
        end
        cyc();
        total++;
        if (z80_rd_rdy !== 1'b0 || fill_busy !== 1'b0 || ram_ce !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_rdy: got rdy=%b busy=%b ce=%b expected 0/0/0",
                     z80_rd_rdy, fill_busy, ram_ce);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << A_W); i++) mem[i] = 8'h00;
        srst       = 1'b1;
        z80_rd_req = 1'b0;
        z80_wr_req = 1'b0;
        z80_addr   = '0;
        z80_wdata  = 8'h00;
        fill_start = 1'b0;
        fill_abort = 1'b0;
        fill_x0    = '0;
        fill_y0    = '0;
        fill_w     = '0;
        fill_h     = '0;
        fill_value = 8'h00;

        test_reset();
        test_fill_basic();
        test_wr_during_fill();
        test_simul_rdwr();
        test_read_pipeline();
        test_wrap();
        test_abort();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hires_access_ctrl.md
HIRES_ACCESS_CTRL -- requirements
Module: hires_access_ctrl

Interface
REQ-001 SHALL have parameter X_W, default 7, hires byte-column address width (0-79 used).
REQ-002 SHALL have parameter Y_W, default 8, hires row address width (0-239 used).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port srst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports z80_rd_req / z80_wr_req  input  1 each  one-cycle Z80 data-port read/write strobes.
REQ-006 SHALL have ports z80_addr  input  X_W+Y_W  {x,y}; z80_wdata  input  8.
REQ-007 SHALL have ports z80_rdata  output  8 and z80_rd_rdy  output  1  read data plus one-cycle valid pulse.
REQ-008 SHALL have ports fill_start  input  1; fill_abort  input  1; fill_x0  input  X_W; fill_y0  input  Y_W; fill_w  input  X_W; fill_h  input  Y_W; fill_value  input  8.
REQ-009 SHALL have ports fill_busy  output  1 and fill_done  output  1  (one-cycle pulse).
REQ-010 SHALL have RAM port-A ports ram_ce, ram_we, ram_regce  output  1 each; ram_addr  output  X_W+Y_W; ram_din  output  8; ram_dout  input  8.

Function
REQ-011 SHALL register all RAM port-A outputs; a request sampled at edge k drives the port during cycle k+1.
REQ-012 SHALL give Z80 absolute priority: any Z80 strobe wins port A unconditionally; fill engine stalls that cycle without advancing.
REQ-013 Z80 write sampled at edge k SHALL present ce=1, we=1, addr=z80_addr, din=z80_wdata in cycle k+1.
REQ-014 Z80 read sampled at edge k SHALL present ce=1, we=0 in cycle k+1, ram_regce=1 in cycle k+2, z80_rd_rdy=1 with z80_rdata=ram_dout in cycle k+3; z80_rdata holds until next read.
REQ-015 Simultaneous z80_rd_req and z80_wr_req SHALL service the read only; the write is dropped.
REQ-016 Fill FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on fill_start, RUN->DONE after last write, DONE->IDLE after one cycle (fill_done=1 in DONE).
REQ-017 fill_start SHALL latch x0,y0,w,h,value; fill_start while busy SHALL be ignored.
REQ-018 fill_start with fill_w==0 or fill_h==0 SHALL go directly to DONE, performing no writes.
REQ-019 In RUN, each non-stalled cycle SHALL issue one write of value at {fx,fy}; x inner loop fx=x0..x0+w-1, then fx=x0, fy+1; y outer loop y0..y0+h-1.
REQ-020 Address arithmetic SHALL wrap modulo 2^X_W and 2^Y_W; no clipping to 80x240.
REQ-021 fill_busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-022 fill_abort in RUN SHALL stop after the current cycle's write and go to DONE; in IDLE or DONE it SHALL have no effect.
REQ-023 A fill of w*h bytes with no Z80 traffic SHALL complete in exactly w*h RUN cycles.
REQ-024 Z80 read of an address already written by the fill SHALL return fill_value (port order = issue order).

Reset
REQ-025 srst SHALL force FSM to IDLE and all outputs to 0 (ram_ce, ram_we, ram_regce, z80_rd_rdy, fill_busy, fill_done, ram_addr, ram_din, z80_rdata), also mid-fill and mid-read; in-flight read pulses SHALL be cancelled.

Structure
REQ-026 Package hires_pkg SHALL hold X_W, Y_W, HIRES_COLS=80, HIRES_ROWS=240, and the fill-state enum.
REQ-027 Sub-module hires_fill_engine (FSM plus x/y counters) SHALL be instantiated once; arbitration and read pipeline stay at top.

Verification
REQ-028 Fill x0=2,y0=10,w=3,h=2,value=A5, no Z80 -> writes at (2,10),(3,10),(4,10),(2,11),(3,11),(4,11); fill_done in cycle 7 after start.
REQ-029 Z80 write x=5,y=5,data=3C during fill -> that cycle ce/we carry Z80 addr/data; fill completes with total writes w*h, none lost or duplicated.
REQ-030 Z80 read at cycle k -> regce at k+2, rd_rdy at k+3 with model data; back-to-back reads at k,k+1 -> rdy at k+3,k+4.
REQ-031 Fill x0=126,w=4,h=1 -> x addresses 126,127,0,1; w=0 -> fill_done after one cycle, zero writes.
REQ-032 fill_abort after 5 writes of 80x240 fill -> exactly 5 or 6 writes, fill_done pulse, busy drops; new fill_start accepted.
REQ-033 srst asserted mid-fill and mid-read -> next cycle all outputs 0, no rd_rdy pulse.
